lif_config_sequencer: RTL
=========================

# lif_config_sequencer

Configuration controller for the LIF neuron system. It accepts a parallel parameter set over a valid/ready handshake and range-checks it. It then serialises the set into the data loader's `load_mode`/`serial_data` interface and waits for the loader's `params_ready` acknowledge. The neuron stays gated off until a frame has been delivered and acknowledged.

## Interface
- `BIT_CYCLES`, default 1: clock cycles each serial bit is held; must be ≥1.
- `READY_TIMEOUT`, default 16: maximum cycles to wait for `params_ready` after the last bit; must be ≥1.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: global enable; when low, all state and outputs freeze.
- `cfg_valid` in 1: a parameter frame is offered.
- `cfg_ready` out 1: high only in IDLE with `enable`=1.
- `cfg_weight_a` in 3: synaptic weight for channel A.
- `cfg_weight_b` in 3: synaptic weight for channel B.
- `cfg_leak` in 2: leak configuration.
- `cfg_thr_min` in 8: lower threshold.
- `cfg_thr_max` in 8: upper threshold.
- `load_mode` out 1: drives the loader's `load_enable`.
- `serial_data` out 1: drives the loader's `serial_data_in`.
- `params_ready` in 1: acknowledge from the loader.
- `neuron_enable` out 1: enable for the neuron; equals `enable & configured & (state==IDLE)`.
- `cfg_busy` out 1: high in SHIFT and WAIT_READY.
- `cfg_done` out 1: one-cycle pulse on successful acknowledge.
- `cfg_error` out 1: sticky error flag; cleared when the next frame is accepted.

## Operation
- **Reset values:** state IDLE; `configured`=0; `load_mode`=0, `serial_data`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_error`=0, `neuron_enable`=0.
- **Frame layout:** 24 bits, sent MSB first.
  - bits [23:21] = `weight_a`
  - bits [20:18] = `weight_b`
  - bits [17:16] = `leak`
  - bits [15:8] = `thr_min`
  - bits [7:0] = `thr_max`
- **Capture:** the frame is registered on accept (`cfg_valid & cfg_ready`). Inputs are don't-care afterwards.
- **IDLE:**
  - On accept: clear `cfg_error`; clear `configured`.
  - If `thr_min > thr_max` (unsigned): set `cfg_error`, stay in IDLE, send no bits.
  - Otherwise go to SHIFT.
- **SHIFT:**
  - `load_mode`=1; `serial_data`=current frame bit.
  - Each bit is held `BIT_CYCLES` cycles; a 5-bit bit counter runs from 23 down to 0.
  - After bit 0 has been held its full time, go to WAIT_READY with `load_mode`=0 and `serial_data`=0.
  - `params_ready` is ignored in SHIFT.
- **WAIT_READY:**
  - A timeout counter counts cycles from 0.
  - `params_ready` sampled high: pulse `cfg_done`, set `configured`, return to IDLE.
  - Counter reaches `READY_TIMEOUT` with no acknowledge: set `cfg_error`, leave `configured`=0, return to IDLE.
  - If acknowledge and timeout fall on the same cycle, the acknowledge wins.
- **`enable`=0:** every counter, the state, and all registered outputs hold their value (`load_mode`/`serial_data` included). `cfg_ready` and `neuron_enable` go low combinationally. No accept can occur.
- **`reset` mid-frame:** reset values apply at the next edge. A partial frame is abandoned and never resumed.
- **Reconfiguration:** a new frame is accepted only in IDLE. `neuron_enable` drops the cycle after the accept and stays low until a successful `cfg_done`.
- Counter widths must hold `BIT_CYCLES-1` and `READY_TIMEOUT` without wrap-around.

## Timing
- **Accept:** occurs at edge E0. The first bit appears on `serial_data` with `load_mode`=1 in the cycle after E0.
- **Shift window:** `load_mode` stays high for exactly 24×`BIT_CYCLES` consecutive enabled cycles, with no gaps.
- **Acknowledge path:** WAIT_READY begins the cycle after `load_mode` falls. `params_ready` high in WAIT_READY cycle k (k=0..`READY_TIMEOUT`-1) puts `cfg_done` high in the following cycle.
- **Best case:** accept to `cfg_done` is 24×`BIT_CYCLES`+2 cycles.
- **Rejected frame:** `cfg_error` rises the cycle after accept; `cfg_ready` stays high.
- **`cfg_busy`:** asserted the cycle after accept; cleared the same cycle `cfg_done` or a timeout error is asserted.
- **Back-to-back frames:** a new frame can be accepted in the same cycle that `cfg_done` is high (state is IDLE).

## Test plan
- **Nominal frame:** reset, then accept w_a=5, w_b=3, leak=2, thr_min=0x20, thr_max=0x80 with `params_ready` returned 1 cycle after `load_mode` falls.
  - `serial_data` sequence = 101 011 10 00100000 10000000.
  - `load_mode` high 24 cycles.
  - `cfg_done` at cycle 27; `neuron_enable`=1 afterwards.
- **`BIT_CYCLES`=3:** same frame.
  - Each bit held 3 cycles; `load_mode` high 72 cycles; bit pattern unchanged.
- **Range check:** `thr_min`=0x90, `thr_max`=0x10.
  - `cfg_error`=1 the next cycle; `load_mode` never rises; `neuron_enable`=0.
  - Equal thresholds (0x40/0x40) are accepted normally.
- **Timeout:** `params_ready` held 0.
  - `cfg_error` rises after 16 WAIT_READY cycles; state returns to IDLE; `configured`=0.
  - The next valid frame clears `cfg_error` on accept.
- **`enable` drop:** drop `enable` for 5 cycles after bit 10.
  - Outputs frozen for those 5 cycles; shifting resumes at bit 9; total `load_mode`-high enabled cycles = 24.
- **Reset mid-shift:** assert `reset` at bit 12.
  - All outputs return to reset values next cycle.
  - A fresh frame afterwards completes with a correct 24-bit pattern.

Source files
------------

// File: rtl/lif_config_sequencer_if.sv
// Bundle of signals between the LIF configuration sequencer, the parameter
// source that offers frames and the serial data loader that acknowledges them.
// The master side is the environment (frame source plus loader).
// The slave side is the sequencer itself.
interface lif_config_sequencer_if;
    // Parameter frame handshake
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_weight_a;
    logic [2:0] cfg_weight_b;
    logic [1:0] cfg_leak;
    logic [7:0] cfg_thr_min;
    logic [7:0] cfg_thr_max;

    // Serial loader link
    logic       load_mode;
    logic       serial_data;
    logic       params_ready;

    // Neuron gating and status
    logic       neuron_enable;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_error;

    modport master (
        output cfg_valid,
        output cfg_weight_a,
        output cfg_weight_b,
        output cfg_leak,
        output cfg_thr_min,
        output cfg_thr_max,
        output params_ready,
        input  cfg_ready,
        input  load_mode,
        input  serial_data,
        input  neuron_enable,
        input  cfg_busy,
        input  cfg_done,
        input  cfg_error
    );

    modport slave (
        input  cfg_valid,
        input  cfg_weight_a,
        input  cfg_weight_b,
        input  cfg_leak,
        input  cfg_thr_min,
        input  cfg_thr_max,
        input  params_ready,
        output cfg_ready,
        output load_mode,
        output serial_data,
        output neuron_enable,
        output cfg_busy,
        output cfg_done,
        output cfg_error
    );
endinterface

// File: rtl/lif_config_sequencer.sv
// Configuration sequencer for the LIF neuron system.
// It takes one parallel parameter frame and range-checks the thresholds.
// It then shifts the frame MSB-first into the loader and waits for the loader
// to acknowledge. The neuron is held off until a frame has been acknowledged.
//
//   state         | meaning
//   --------------+-----------------------------------------------------------
//   ST_IDLE       | ready for a frame; neuron enabled if last frame was acked
//   ST_SHIFT      | load_mode high, one frame bit on serial_data per bit slot
//   ST_WAIT_READY | frame sent, waiting for params_ready or the timeout
//
// With enable_i low the whole block freezes: state, counters and registered
// outputs all hold. Only cfg_ready and neuron_enable fall, because they are
// combinational.
module lif_config_sequencer #(
    parameter int BIT_CYCLES    = 1,
    parameter int READY_TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    lif_config_sequencer_if.slave  cfg_if
);
    // Hold counter reloads with BIT_CYCLES-1; timeout counter must reach READY_TIMEOUT-1
    localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int TO_W   = $clog2(READY_TIMEOUT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(BIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(READY_TIMEOUT - 1);
    localparam logic [4:0]        FIRST_BIT = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SHIFT      = 2'd1,
        ST_WAIT_READY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [23:0]         frame_q, frame_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                load_mode_q, load_mode_d;
    logic                serial_data_q, serial_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                configured_q, configured_d;

    logic                cfg_ready;
    logic                accept;
    logic                range_ok;
    logic [23:0]         frame_in;
    logic [4:0]          next_bit;

    assign cfg_ready = enable_i & (state_q == ST_IDLE);
    assign accept    = cfg_ready & cfg_if.cfg_valid;
    assign range_ok  = (cfg_if.cfg_thr_min <= cfg_if.cfg_thr_max);
    assign frame_in  = {cfg_if.cfg_weight_a, cfg_if.cfg_weight_b, cfg_if.cfg_leak,
                        cfg_if.cfg_thr_min, cfg_if.cfg_thr_max};
    assign next_bit  = bit_cnt_q - 5'd1;

    // State and registered outputs; everything holds while enable_i is low
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            to_cnt_q      <= '0;
            load_mode_q   <= 1'b0;
            serial_data_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            configured_q  <= 1'b0;
        end else if (enable_i) begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            to_cnt_q      <= to_cnt_d;
            load_mode_q   <= load_mode_d;
            serial_data_q <= serial_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            configured_q  <= configured_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        bit_cnt_d     = bit_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        to_cnt_d      = to_cnt_q;
        load_mode_d   = load_mode_q;
        serial_data_d = serial_data_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;
        configured_d  = configured_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    frame_d      = frame_in;
                    error_d      = 1'b0;
                    configured_d = 1'b0;
                    if (!range_ok) begin
                        // Rejected frame: flag it and stay ready for the next one
                        error_d = 1'b1;
                    end else begin
                        // First bit goes out straight from the incoming frame so it
                        // is on the line the cycle after the accept
                        state_d       = ST_SHIFT;
                        bit_cnt_d     = FIRST_BIT;
                        hold_cnt_d    = HOLD_LOAD;
                        load_mode_d   = 1'b1;
                        serial_data_d = frame_in[23];
                        busy_d        = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else if (bit_cnt_q == 5'd0) begin
                    state_d       = ST_WAIT_READY;
                    load_mode_d   = 1'b0;
                    serial_data_d = 1'b0;
                    to_cnt_d      = '0;
                end else begin
                    bit_cnt_d     = next_bit;
                    hold_cnt_d    = HOLD_LOAD;
                    serial_data_d = frame_q[next_bit];
                end
            end

            ST_WAIT_READY: begin
                // Acknowledge is checked first so it wins over a same-cycle timeout
                if (cfg_if.params_ready) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    configured_d = 1'b1;
                    busy_d       = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            default: begin
                state_d       = ST_IDLE;
                load_mode_d   = 1'b0;
                serial_data_d = 1'b0;
                busy_d        = 1'b0;
            end
        endcase
    end

    assign cfg_if.cfg_ready     = cfg_ready;
    assign cfg_if.load_mode     = load_mode_q;
    assign cfg_if.serial_data   = serial_data_q;
    assign cfg_if.cfg_busy      = busy_q;
    assign cfg_if.cfg_done      = done_q;
    assign cfg_if.cfg_error     = error_q;
    assign cfg_if.neuron_enable = enable_i & configured_q & (state_q == ST_IDLE);

endmodule
